// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: accepts one line read/write per transaction into a 64-bit word array
// and answers with a read burst or a single write-completion beat. Optional macro: BUS_RESP_CWF_EN.
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BURST_LEN      = 8,
  parameter int MEM_WORDS      = 4096,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BURST_LEN);
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WDATA, LAT, RESP} state_t;

  state_t                     state_q;
  logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];
  logic [AW-BW-1:0]           line_q;
  logic [BW-1:0]              off_q;
  logic [BW-1:0]              beat_q;
  logic [LW-1:0]              lat_q;
  logic                       is_write_q;
  logic                       reqack_q;
  logic                       respcyc_q;
  logic [BUS_DATA_WIDTH-1:0]  resp_q;
  logic [BUS_TAG_WIDTH-1:0]   resptag_q;

  logic [BW-1:0]              hdr_off;
  logic [BW-1:0]              cur_idx;
  logic [BW-1:0]              next_idx;
  logic                       wr_en;

`ifdef BUS_RESP_CWF_EN
  assign hdr_off = bus_req[3 +: BW];
`else
  assign hdr_off = '0;
`endif

  assign cur_idx  = off_q + beat_q;
  assign next_idx = cur_idx + BW'(1);

  // The reqack cycle still carries the held header, so data beats start the cycle after it.
  assign wr_en = (state_q == WDATA) && bus_reqcyc && !reqack_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{line_q, cur_idx}] <= bus_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      off_q      <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      is_write_q <= 1'b0;
      reqack_q   <= 1'b0;
      respcyc_q  <= 1'b0;
      resp_q     <= '0;
      resptag_q  <= '0;
    end else begin
      reqack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_reqcyc) begin
            reqack_q   <= 1'b1;
            line_q     <= bus_req[3+BW +: AW-BW];
            off_q      <= hdr_off;
            beat_q     <= '0;
            lat_q      <= LW'(LATENCY);
            is_write_q <= bus_reqtag[BUS_TAG_WIDTH-1];
            resptag_q  <= bus_reqtag;
            state_q    <= bus_reqtag[BUS_TAG_WIDTH-1] ? WDATA : LAT;
          end
        end
        WDATA: begin
          if (wr_en) begin
            if (beat_q == BW'(BURST_LEN - 1)) begin
              beat_q  <= '0;
              lat_q   <= LW'(LATENCY);
              state_q <= LAT;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        LAT: begin
          if (lat_q == LW'(1)) begin
            state_q   <= RESP;
            respcyc_q <= 1'b1;
            resp_q    <= is_write_q ? '0 : mem[{line_q, cur_idx}];
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        RESP: begin
          // Beat stays on the bus until acked; next beat follows on the very next cycle.
          if (bus_respack) begin
            if (is_write_q || beat_q == BW'(BURST_LEN - 1)) begin
              state_q   <= IDLE;
              respcyc_q <= 1'b0;
            end else begin
              beat_q <= beat_q + BW'(1);
              resp_q <= mem[{line_q, next_idx}];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized + directed bench for bus_mem_responder against a word-array line model.
// Honours BUS_RESP_CWF_EN for expected beat ordering.
module tb_bus_mem_responder;

  localparam int BL  = 8;
  localparam int MW  = 4096;
  localparam int LAT = 4;
  localparam int AW  = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  bus_mem_responder #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BURST_LEN(BL), .MEM_WORDS(MW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] model [MW];
  logic [63:0] exp_q [$];
  logic [63:0] wdata [BL];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word index of beat i of the line holding addr, in the order the bus moves it.
  function automatic int widx(input logic [63:0] addr, input int i);
    int w, base, off;
    w    = int'(addr[3 +: AW]);
    base = w - (w % BL);
`ifdef BUS_RESP_CWF_EN
    off = w % BL;
`else
    off = 0;
`endif
    return base + ((off + i) % BL);
  endfunction

  task automatic build_exp(input logic [63:0] addr);
    exp_q.delete();
    for (int i = 0; i < BL; i++) exp_q.push_back(model[widx(addr, i)]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_header(input logic [63:0] addr, input logic [12:0] tag, output int waited);
    bus_req = addr; bus_reqtag = tag; bus_reqcyc = 1'b1; waited = 0;
    do begin
      @(posedge clk); #1; waited++;
    end while (!bus_reqack && waited < 100);
    bus_reqcyc = 1'b0;
    check("hdr_ack_seen", 64'(bus_reqack), 64'd1);
  endtask

  // Mode 0: ack always; 1: ack held low 3 cycles on beats 1 and 4; 2: random ack.
  task automatic get_resp(input int nbeats, input logic [12:0] tag, input int mode, input bit chk_noack,
                          input int abort_at, output int lat, output bit aborted);
    int  beat, stall, cyc;
    bit  a;
    lat = 0; aborted = 1'b0;
    while (!bus_respcyc && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (chk_noack) check("no_reqack_busy", 64'(bus_reqack), 64'd0);
    end
    check("resp_started", 64'(bus_respcyc), 64'd1);
    beat = 0; stall = 0; cyc = 0;
    while (beat < nbeats && cyc < 300) begin
      check("respcyc", 64'(bus_respcyc), 64'd1);
      check("resp_data", bus_resp, exp_q[beat]);
      check("resp_tag", 64'(bus_resptag), 64'(tag));
      if (beat == abort_at) begin
        do_reset();
        aborted = 1'b1;
        return;
      end
      case (mode)
        0:       a = 1'b1;
        1:       a = !(((beat == 1) || (beat == 4)) && stall < 3);
        default: a = 1'($urandom_range(0, 1));
      endcase
      bus_respack = a;
      @(posedge clk); #1; cyc++;
      if (a) begin beat++; stall = 0; end else stall++;
      if (chk_noack) check("no_reqack_busy", 64'(bus_reqack), 64'd0);
    end
    bus_respack = 1'b0;
    if (mode == 0) check("burst_cycles", 64'(cyc), 64'(nbeats));
    check("resp_done", 64'(bus_respcyc), 64'd0);
  endtask

  task automatic read_txn(input logic [63:0] addr, input logic [12:0] tag, input int mode, input int abort_at);
    int waited, lat;
    bit aborted;
    build_exp(addr);
    do_header(addr, tag, waited);
    check("rd_hdr_wait", 64'(waited), 64'd1);
    get_resp(BL, tag, mode, 1'b0, abort_at, lat, aborted);
    check("rd_latency", 64'(lat), 64'(LAT));
    $display("[TB] read  addr=0x%h tag=0x%h mode=%0d aborted=%0d", addr, tag, mode, aborted);
  endtask

  task automatic write_txn(input logic [63:0] addr, input logic [12:0] tag, input bit bubbles, input int abort_after);
    int waited, lat;
    bit aborted;
    do_header(addr, tag, waited);
    check("wr_hdr_wait", 64'(waited), 64'd1);
    @(posedge clk); #1;
    check("reqack_pulse", 64'(bus_reqack), 64'd0);
    for (int i = 0; i < BL; i++) begin
      if (i == abort_after) begin
        bus_reqcyc = 1'b0;
        do_reset();
        $display("[TB] write addr=0x%h tag=0x%h reset after %0d beats", addr, tag, i);
        return;
      end
      if (bubbles && $urandom_range(0, 2) == 0) begin
        bus_reqcyc = 1'b0;
        @(posedge clk); #1;
      end
      bus_reqcyc = 1'b1; bus_req = wdata[i];
      @(posedge clk); #1;
      model[widx(addr, i)] = wdata[i];
    end
    bus_reqcyc = 1'b0;
    exp_q.delete(); exp_q.push_back(64'd0);
    get_resp(1, tag, bubbles ? 2 : 0, 1'b0, -1, lat, aborted);
    check("wr_latency", 64'(lat), 64'(LAT));
    $display("[TB] write addr=0x%h tag=0x%h bubbles=%0d", addr, tag, bubbles);
  endtask

  initial begin
    int          waited, lat;
    bit          aborted;
    logic [63:0] addr, raddr;

    for (int i = 0; i < MW; i++) model[i] = 64'd0;
    bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_reqack", 64'(bus_reqack), 64'd0);
    check("reset_respcyc", 64'(bus_respcyc), 64'd0);
    check("reset_resp", bus_resp, 64'd0);
    check("reset_resptag", 64'(bus_resptag), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Directed line 0x1000: write, in-order read, stalled read, critical-word read.
    for (int i = 0; i < BL; i++) wdata[i] = 64'h11 * (i + 1);
    write_txn(64'h1000, 13'h1005, 1'b0, -1);
    read_txn(64'h1000, 13'h0007, 0, -1);
    read_txn(64'h1000, 13'h0007, 1, -1);
    read_txn(64'h1018, 13'h0007, 0, -1);

    bus_respack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ack_ignored", 64'(bus_respcyc), 64'd0);
    end
    bus_respack = 1'b0;

    // Reset during the third read beat, then the line must still read back intact.
    read_txn(64'h1000, 13'h0007, 0, 2);
    read_txn(64'h1000, 13'h0009, 0, -1);

    // Reset after three write beats keeps those three, leaves the rest unchanged.
    for (int i = 0; i < BL; i++) wdata[i] = 64'hA0 + i;
    write_txn(64'h1000, 13'h1001, 1'b0, 3);
    read_txn(64'h1000, 13'h0002, 0, -1);

    // Address above the array aliases modulo MEM_WORDS.
    for (int i = 0; i < BL; i++) wdata[i] = 64'hC0DE_0000 + i;
    write_txn(64'h0000_0001_0000_9040, 13'h1ABC, 1'b0, -1);
    read_txn(64'h1040, 13'h0ABC, 0, -1);

    // Second header held during RESP: no ack until IDLE, then accepted on the first idle edge.
    build_exp(64'h1000);
    do_header(64'h1000, 13'h0011, waited);
    bus_req = 64'h1040; bus_reqtag = 13'h0022; bus_reqcyc = 1'b1;
    get_resp(BL, 13'h0011, 1, 1'b1, -1, lat, aborted);
    check("busy_rd_latency", 64'(lat), 64'(LAT));
    @(posedge clk); #1;
    check("held_hdr_acked", 64'(bus_reqack), 64'd1);
    bus_reqcyc = 1'b0;
    build_exp(64'h1040);
    get_resp(BL, 13'h0022, 0, 1'b0, -1, lat, aborted);
    check("queued_rd_latency", 64'(lat), 64'(LAT));
    $display("[TB] read  addr=0x1040 tag=0x0022 queued behind busy read");

    // Random lines, random data, bubbles and random acks.
    for (int t = 0; t < 6; t++) begin
      addr = {$urandom, $urandom};
      for (int i = 0; i < BL; i++) wdata[i] = {$urandom, $urandom};
      write_txn(addr, {1'b1, 12'($urandom)}, 1'b1, -1);
      raddr = addr;
      raddr[5:3] = 3'($urandom_range(0, 7));
      read_txn(raddr, {1'b0, 12'($urandom)}, 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
